value_weight_dot_accumulator: RTL and testbench
===============================================

Name: value_weight_dot_accumulator

Overview:
- Streaming fixed-point dot-product accumulator, directly downstream of the attention value-weight source.
- Joins an activation stream with the weight stream beat by beat and multiplies PARALLELISM element pairs per beat.
- Reduces the products with an adder tree and accumulates IN_DEPTH beats into one full-precision signed result.
- Feeds the value-projection output path of the attention block.

Parameters:
DATA_IN_PRECISION_0, 16, activation element width (signed two's complement)
WEIGHT_PRECISION_0, 16, weight element width (signed)
PARALLELISM, 4, element pairs per beat
TENSOR_SIZE_DIM_0, 32, elements per dot product; must be a multiple of PARALLELISM
IN_DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM, beats per dot product; must be ≥ 1
DATA_OUT_PRECISION_0, DATA_IN_PRECISION_0+WEIGHT_PRECISION_0+$clog2(PARALLELISM)+$clog2(IN_DEPTH), result width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_in  in  [DATA_IN_PRECISION_0-1:0] x PARALLELISM  activation elements
data_in_valid  in  1  activation beat valid
data_in_ready  out  1  activation beat accepted
weight  in  [WEIGHT_PRECISION_0-1:0] x PARALLELISM  weight elements
weight_valid  in  1  weight beat valid
weight_ready  out  1  weight beat accepted
data_out  out  [DATA_OUT_PRECISION_0-1:0]  dot-product result
data_out_valid  out  1  result valid
data_out_ready  in  1  downstream ready

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: beat counter 0, accumulator 0, data_out 0, data_out_valid 0.
- Join rule:
  - accept = data_in_valid & weight_valid & can_accept.
  - data_in_ready = weight_valid & can_accept.
  - weight_ready = data_in_valid & can_accept.
  - A beat is never consumed from one stream without the other.
- can_accept = !(counter==IN_DEPTH-1 & data_out_valid & !data_out_ready).
  - Accumulation of the next group continues while a result is held.
  - Only the final beat of the next group stalls.
- Arithmetic:
  - Elementwise signed product at width DATA_IN_PRECISION_0+WEIGHT_PRECISION_0.
  - Combinational sign-extending adder tree adds $clog2(PARALLELISM) bits.
  - Accumulator is DATA_OUT_PRECISION_0 bits.
  - No rounding, truncation or saturation.
- On accept with counter<IN_DEPTH-1: acc <= acc + beat_sum; counter++.
- On accept with counter==IN_DEPTH-1:
  - data_out <= acc + beat_sum; data_out_valid <= 1.
  - acc <= 0; counter <= 0.
- Latency: result is valid the cycle after the final beat is accepted.
- Output hold: data_out and data_out_valid stay stable until data_out_ready is high while valid.
- Simultaneous drain and new result: if the result is taken in the same cycle a new final beat is accepted, data_out_valid stays 1 and data_out updates to the new value (back-to-back, no bubble).
- Drain only (no new result): data_out_valid <= 0; data_out keeps its value.
- IN_DEPTH==1: every accepted beat produces a result.
- Reset mid-group: partial accumulation is discarded; the counter restarts at 0; any pending output is dropped.
- Inputs with X while not accepted must not corrupt state.

Decomposition:
- Shared package `attention_fixed_pkg`:
  - precision localparams and width-derivation constants (product width, tree growth, DATA_OUT_PRECISION_0 formula).
  - a signed sign-extension helper function.
- Sub-module `fixed_adder_tree`:
  - parameterised IN_SIZE, IN_WIDTH; purely combinational signed reduction with width growth $clog2(IN_SIZE).
  - instantiated once for the beat sum.

Test Plan:
1. Defaults. 8 beats of data=1 (x4) and weight=1 (x4), both valid, data_out_ready=1 → one result of 32, valid exactly 1 cycle after the 8th accept.
2. data=0xFFFF (-1) x4 and weight=2 x4 for 8 beats → data_out = -64, sign-extended to 37 bits. Then data=0x8000 and weight=0x8000 for all beats → +2^30·32 = 2^35 with no overflow.
3. Random independent valid toggling on both inputs (weight_valid low 50% of cycles) → no beat is consumed without its partner, and results match the golden model over 20 groups.
4. Hold data_out_ready=0 after the first result and keep streaming → the second group stalls exactly at its 8th beat (both readies low), the first result stays stable, and raising ready yields both results in order with no bubble.
5. Assert rst after 5 beats of a group → the next 8 beats produce a result equal only to their own sum, and data_out_valid is 0 during and after reset.
6. PARALLELISM=4, TENSOR_SIZE_DIM_0=4 (IN_DEPTH=1): data 1,2,3,4 with weights 5,6,7,8 → 70 each beat, with continuous throughput of 1 result per cycle.

Source files
------------

// File: rtl/attention_fixed_pkg.sv
// Shared fixed-point width rules and helpers for the attention datapath.
// Widths grow exactly enough that no product, tree or accumulator stage can overflow.
package attention_fixed_pkg;

    localparam int DEFAULT_DATA_IN_PRECISION = 16;
    localparam int DEFAULT_WEIGHT_PRECISION  = 16;
    localparam int DEFAULT_PARALLELISM       = 4;
    localparam int DEFAULT_TENSOR_SIZE       = 32;

    localparam int SEXT_MAX_WIDTH = 128;
    localparam int SEXT_IDX_WIDTH = $clog2(SEXT_MAX_WIDTH);

    function automatic int product_width(input int data_w, input int weight_w);
        return data_w + weight_w;
    endfunction

    function automatic int tree_growth(input int size);
        return $clog2(size);
    endfunction

    function automatic int dot_out_width(input int data_w, input int weight_w,
                                         input int par, input int depth);
        return product_width(data_w, weight_w) + tree_growth(par) + tree_growth(depth);
    endfunction

    // Replicates bit width-1 of value into every bit above it; callers cast to their width.
    function automatic logic [SEXT_MAX_WIDTH-1:0] sign_extend(
        input logic [SEXT_MAX_WIDTH-1:0] value,
        input int                        width
    );
        logic [SEXT_MAX_WIDTH-1:0] mask;
        mask = '1;
        mask = mask >> (SEXT_MAX_WIDTH - width);
        return value[SEXT_IDX_WIDTH'(width - 1)] ? (value | ~mask) : (value & mask);
    endfunction

endpackage

// File: rtl/fixed_adder_tree.sv
// Combinational signed reduction tree; every node carries the final width so no stage overflows.
module fixed_adder_tree
    import attention_fixed_pkg::*;
#(
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = IN_WIDTH + tree_growth(IN_SIZE)
)(
    input  logic [IN_SIZE*IN_WIDTH-1:0] data_in,
    output logic [OUT_WIDTH-1:0]        data_out
);

    localparam int LEVELS = tree_growth(IN_SIZE);
    localparam int LEAVES = 1 << LEVELS;

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_level
            localparam int NODES = LEAVES >> gi;
            logic [OUT_WIDTH-1:0] node [NODES];

            if (gi == 0) begin : g_leaf
                // Non-power-of-two sizes are padded with zero leaves.
                for (gj = 0; gj < NODES; gj++) begin : g_in
                    if (gj < IN_SIZE) begin : g_used
                        assign node[gj] = OUT_WIDTH'(sign_extend(
                            SEXT_MAX_WIDTH'(data_in[gj*IN_WIDTH +: IN_WIDTH]), IN_WIDTH));
                    end else begin : g_pad
                        assign node[gj] = '0;
                    end
                end
            end else begin : g_sum
                for (gj = 0; gj < NODES; gj++) begin : g_add
                    assign node[gj] = g_level[gi-1].node[2*gj] + g_level[gi-1].node[2*gj+1];
                end
            end
        end
    endgenerate

    assign data_out = g_level[LEVELS].node[0];

endmodule

// File: rtl/value_weight_dot_accumulator.sv
// Joins activation and weight beats, multiplies element pairs, and accumulates IN_DEPTH
// beats into one full-precision signed dot product with a single-entry output register.
module value_weight_dot_accumulator
    import attention_fixed_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = DEFAULT_DATA_IN_PRECISION,
    parameter int WEIGHT_PRECISION_0   = DEFAULT_WEIGHT_PRECISION,
    parameter int PARALLELISM          = DEFAULT_PARALLELISM,
    parameter int TENSOR_SIZE_DIM_0    = DEFAULT_TENSOR_SIZE,
    parameter int IN_DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM,
    parameter int DATA_OUT_PRECISION_0 = dot_out_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0,
                                                       PARALLELISM, IN_DEPTH)
)(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PARALLELISM*DATA_IN_PRECISION_0-1:0] data_in,
    input  logic                                      data_in_valid,
    output logic                                      data_in_ready,
    input  logic [PARALLELISM*WEIGHT_PRECISION_0-1:0]  weight,
    input  logic                                      weight_valid,
    output logic                                      weight_ready,
    output logic [DATA_OUT_PRECISION_0-1:0]            data_out,
    output logic                                      data_out_valid,
    input  logic                                      data_out_ready
);

    localparam int PROD_W = product_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0);
    localparam int SUM_W  = PROD_W + tree_growth(PARALLELISM);
    localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

    logic [PARALLELISM*PROD_W-1:0]   products;
    logic [SUM_W-1:0]                beat_sum;
    logic [DATA_OUT_PRECISION_0-1:0] beat_sum_ext;
    logic [DATA_OUT_PRECISION_0-1:0] acc_sum;

    logic [CNT_W-1:0]                counter_reg;
    logic [DATA_OUT_PRECISION_0-1:0] acc_reg;
    logic [DATA_OUT_PRECISION_0-1:0] out_reg;
    logic                            out_valid_reg;

    logic last_beat;
    logic can_accept;
    logic accept;

    genvar gi;
    generate
        for (gi = 0; gi < PARALLELISM; gi++) begin : g_mul
            logic signed [DATA_IN_PRECISION_0-1:0] a;
            logic signed [WEIGHT_PRECISION_0-1:0]  b;
            logic signed [PROD_W-1:0]              p;
            assign a = data_in[gi*DATA_IN_PRECISION_0 +: DATA_IN_PRECISION_0];
            assign b = weight[gi*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
            assign p = PROD_W'(a) * PROD_W'(b);
            assign products[gi*PROD_W +: PROD_W] = p;
        end
    endgenerate

    fixed_adder_tree #(
        .IN_SIZE  (PARALLELISM),
        .IN_WIDTH (PROD_W),
        .OUT_WIDTH(SUM_W)
    ) u_beat_tree (
        .data_in (products),
        .data_out(beat_sum)
    );

    assign beat_sum_ext = DATA_OUT_PRECISION_0'(sign_extend(SEXT_MAX_WIDTH'(beat_sum), SUM_W));
    assign acc_sum      = acc_reg + beat_sum_ext;

    // Earlier beats of the next group keep flowing while a result is held;
    // only the closing beat must wait for the output register to free up.
    assign last_beat     = (counter_reg == LAST_BEAT);
    assign can_accept    = !(last_beat && out_valid_reg && !data_out_ready);
    assign data_in_ready = weight_valid && can_accept;
    assign weight_ready  = data_in_valid && can_accept;
    assign accept        = data_in_valid && weight_valid && can_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg   <= '0;
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_valid_reg && data_out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                if (last_beat) begin
                    out_reg       <= acc_sum;
                    out_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    counter_reg   <= '0;
                end else begin
                    acc_reg     <= acc_sum;
                    counter_reg <= counter_reg + 1'b1;
                end
            end
        end
    end

    assign data_out       = out_reg;
    assign data_out_valid = out_valid_reg;

endmodule

// File: tb/tb_value_weight_dot_accumulator.sv
// Randomised and directed bench for the streaming dot-product accumulator, with a
// plain-arithmetic reference model (beat sums as longint, groups as a queue).
module tb_value_weight_dot_accumulator;

    localparam int DW_IN  = 16;
    localparam int PAR    = 4;
    localparam int DEPTH  = 8;
    localparam int DOUT   = DW_IN + DW_IN + $clog2(PAR) + $clog2(DEPTH);
    localparam int DOUT1  = DW_IN + DW_IN + $clog2(PAR);

    logic             clk;
    logic             rst;
    logic [63:0]      data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [63:0]      weight;
    logic             weight_valid;
    logic             weight_ready;
    logic [DOUT-1:0]  data_out;
    logic             data_out_valid;
    logic             data_out_ready;

    logic [63:0]      d1_data_in;
    logic             d1_data_in_valid;
    logic             d1_data_in_ready;
    logic [63:0]      d1_weight;
    logic             d1_weight_valid;
    logic             d1_weight_ready;
    logic [DOUT1-1:0] d1_data_out;
    logic             d1_data_out_valid;
    logic             d1_data_out_ready;

    int n_vec = 0;
    int n_err = 0;

    value_weight_dot_accumulator dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    value_weight_dot_accumulator #(.TENSOR_SIZE_DIM_0(4)) dut1 (
        .clk(clk), .rst(rst),
        .data_in(d1_data_in), .data_in_valid(d1_data_in_valid), .data_in_ready(d1_data_in_ready),
        .weight(d1_weight), .weight_valid(d1_weight_valid), .weight_ready(d1_weight_ready),
        .data_out(d1_data_out), .data_out_valid(d1_data_out_valid),
        .data_out_ready(d1_data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum of signed elementwise products of one beat.
    function automatic longint beat_value(input logic [63:0] d, input logic [63:0] w);
        longint s;
        logic [15:0] de, we;
        s = 0;
        for (int i = 0; i < PAR; i++) begin
            de = d[i*16 +: 16];
            we = w[i*16 +: 16];
            s += longint'($signed(de)) * longint'($signed(we));
        end
        return s;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        data_in_valid = 1'b0; weight_valid = 1'b0; data_out_ready = 1'b1;
        d1_data_in_valid = 1'b0; d1_weight_valid = 1'b0; d1_data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_in = rand64(); weight = rand64();
        data_in_valid = 1'b1; weight_valid = 1'b1; data_out_ready = 1'b0;
        d1_data_in_valid = 1'b1; d1_weight_valid = 1'b1; d1_data_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
        n_vec++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_vec++; if (d1_data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_d1_valid: got %b want 0", d1_data_out_valid); end
        rst = 1'b0;
        data_in_valid = 1'b0; weight_valid = 1'b1; data_out_ready = 1'b1;
        d1_data_in_valid = 1'b0; d1_weight_valid = 1'b0; d1_data_out_ready = 1'b1;
        #1;
        n_vec++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL join_data_ready: got %b want 1", data_in_ready); end
        n_vec++; if (weight_ready !== 1'b0) begin n_err++; $display("FAIL join_weight_ready: got %b want 0", weight_ready); end
        weight_valid = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_ones();
        do_reset();
        data_out_ready = 1'b1;
        for (int b = 0; b < DEPTH; b++) begin
            data_in = {4{16'd1}}; weight = {4{16'd1}};
            data_in_valid = 1'b1; weight_valid = 1'b1;
            #1;
            n_vec++; if (data_in_ready !== 1'b1 || weight_ready !== 1'b1) begin n_err++; $display("FAIL ones_ready beat %0d: got %b%b want 11", b, data_in_ready, weight_ready); end
            n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL ones_early_valid beat %0d: got %b want 0", b, data_out_valid); end
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0; weight_valid = 1'b0;
        #1;
        n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL ones_valid: got %b want 1", data_out_valid); end
        n_vec++; if (data_out !== DOUT'(32)) begin n_err++; $display("FAIL ones_data: got %0d want 32", data_out); end
        @(posedge clk); #1;
        n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL ones_one_cycle: got %b want 0", data_out_valid); end
        $display("test_ones result=%0d", data_out);
    endtask

    task automatic test_signed();
        logic [15:0]     pd  [2];
        logic [15:0]     pw  [2];
        longint          pexp[2];
        logic [DOUT-1:0] e;
        pd[0] = 16'hFFFF; pw[0] = 16'd2;     pexp[0] = -64;
        pd[1] = 16'h8000; pw[1] = 16'h8000;  pexp[1] = 64'sd1 <<< 35;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < DEPTH; b++) begin
                data_in = {4{pd[p]}}; weight = {4{pw[p]}};
                data_in_valid = 1'b1; weight_valid = 1'b1;
                @(posedge clk); #1;
            end
            data_in_valid = 1'b0; weight_valid = 1'b0;
            #1;
            e = DOUT'(pexp[p]);
            n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL signed_valid pat %0d: got %b want 1", p, data_out_valid); end
            n_vec++; if (data_out !== e) begin n_err++; $display("FAIL signed_data pat %0d: got %h want %h", p, data_out, e); end
            $display("test_signed pattern %0d result=%h", p, data_out);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_join();
        longint grp[$];
        longint m_out, s, bv;
        logic   m_valid, can, acc;
        int     taken;
        do_reset();
        m_valid = 1'b0; m_out = 0; taken = 0;
        for (int cyc = 0; cyc < 3000 && taken < 20; cyc++) begin
            data_in_valid  = ($urandom_range(0, 9) < 7);
            weight_valid   = ($urandom_range(0, 1) == 1);
            data_out_ready = ($urandom_range(0, 9) < 6);
            data_in = data_in_valid ? rand64() : 'x;
            weight  = weight_valid  ? rand64() : 'x;
            #1;
            can = !(grp.size() == DEPTH - 1 && m_valid && !data_out_ready);
            n_vec++; if (data_in_ready !== (weight_valid && can) || weight_ready !== (data_in_valid && can)) begin
                n_err++; $display("FAIL rand_join cyc %0d: got %b%b want %b%b", cyc, data_in_ready, weight_ready, weight_valid && can, data_in_valid && can);
            end
            n_vec++; if (data_out_valid !== m_valid) begin n_err++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, data_out_valid, m_valid); end
            if (m_valid) begin
                n_vec++; if (data_out !== DOUT'(m_out)) begin n_err++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, data_out, DOUT'(m_out)); end
            end
            acc = data_in_valid && weight_valid && can;
            if (m_valid && data_out_ready) begin
                m_valid = 1'b0;
                taken++;
                $display("test_random_join result %0d = %0d", taken, m_out);
            end
            if (acc) begin
                bv = beat_value(data_in, weight);
                grp.push_back(bv);
                if (grp.size() == DEPTH) begin
                    s = 0;
                    foreach (grp[i]) s += grp[i];
                    m_out = s; m_valid = 1'b1;
                    grp.delete();
                end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (taken < 20) begin n_err++; $display("FAIL rand_budget: got %0d results want 20", taken); end
        data_in_valid = 1'b0; weight_valid = 1'b0; data_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        longint sum_a, sum_b, bv;
        logic [63:0] d, w;
        do_reset();
        sum_a = 0; sum_b = 0;
        data_out_ready = 1'b1;
        for (int b = 0; b < DEPTH; b++) begin
            data_in = rand64(); weight = rand64();
            sum_a += beat_value(data_in, weight);
            data_in_valid = 1'b1; weight_valid = 1'b1;
            @(posedge clk); #1;
        end
        data_out_ready = 1'b0;
        for (int b = 0; b < DEPTH - 1; b++) begin
            data_in = rand64(); weight = rand64();
            #1;
            n_vec++; if (data_in_ready !== 1'b1 || weight_ready !== 1'b1) begin n_err++; $display("FAIL bp_early_ready beat %0d: got %b%b want 11", b, data_in_ready, weight_ready); end
            n_vec++; if (data_out_valid !== 1'b1 || data_out !== DOUT'(sum_a)) begin n_err++; $display("FAIL bp_hold beat %0d: got %b/%h want 1/%h", b, data_out_valid, data_out, DOUT'(sum_a)); end
            sum_b += beat_value(data_in, weight);
            @(posedge clk); #1;
        end
        d = rand64(); w = rand64();
        data_in = d; weight = w;
        bv = beat_value(d, w);
        for (int s = 0; s < 3; s++) begin
            #1;
            n_vec++; if (data_in_ready !== 1'b0 || weight_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall cyc %0d: got %b%b want 00", s, data_in_ready, weight_ready); end
            n_vec++; if (data_out_valid !== 1'b1 || data_out !== DOUT'(sum_a)) begin n_err++; $display("FAIL bp_stall_hold cyc %0d: got %b/%h want 1/%h", s, data_out_valid, data_out, DOUT'(sum_a)); end
            @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
        #1;
        n_vec++; if (data_in_ready !== 1'b1 || weight_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b%b want 11", data_in_ready, weight_ready); end
        sum_b += bv;
        @(posedge clk); #1;
        data_in_valid = 1'b0; weight_valid = 1'b0;
        #1;
        n_vec++; if (data_out_valid !== 1'b1 || data_out !== DOUT'(sum_b)) begin n_err++; $display("FAIL bp_no_bubble: got %b/%h want 1/%h", data_out_valid, data_out, DOUT'(sum_b)); end
        @(posedge clk); #1;
        n_vec++; if (data_out_valid !== 1'b0 || data_out !== DOUT'(sum_b)) begin n_err++; $display("FAIL bp_drain: got %b/%h want 0/%h", data_out_valid, data_out, DOUT'(sum_b)); end
        $display("test_backpressure results %0d then %0d", sum_a, sum_b);
    endtask

    task automatic test_reset_mid_group();
        longint sum_c;
        do_reset();
        data_out_ready = 1'b0;
        for (int b = 0; b < DEPTH + 5; b++) begin
            data_in = rand64(); weight = rand64();
            data_in_valid = 1'b1; weight_valid = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", data_out_valid); end
        rst = 1'b1;
        data_in = rand64(); weight = rand64();
        @(posedge clk); #1;
        n_vec++; if (data_out_valid !== 1'b0 || data_out !== '0) begin n_err++; $display("FAIL mid_reset: got %b/%h want 0/0", data_out_valid, data_out); end
        rst = 1'b0;
        data_out_ready = 1'b1;
        sum_c = 0;
        for (int b = 0; b < DEPTH; b++) begin
            data_in = rand64(); weight = rand64();
            #1;
            n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid beat %0d: got %b want 0", b, data_out_valid); end
            sum_c += beat_value(data_in, weight);
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0; weight_valid = 1'b0;
        #1;
        n_vec++; if (data_out_valid !== 1'b1 || data_out !== DOUT'(sum_c)) begin n_err++; $display("FAIL mid_result: got %b/%h want 1/%h", data_out_valid, data_out, DOUT'(sum_c)); end
        $display("test_reset_mid_group result=%0d", sum_c);
        @(posedge clk); #1;
    endtask

    task automatic test_depth_one();
        longint prev;
        do_reset();
        prev = 0;
        d1_data_out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k < 4) begin
                d1_data_in = {16'd4, 16'd3, 16'd2, 16'd1};
                d1_weight  = {16'd8, 16'd7, 16'd6, 16'd5};
            end else begin
                d1_data_in = rand64(); d1_weight = rand64();
            end
            d1_data_in_valid = 1'b1; d1_weight_valid = 1'b1;
            #1;
            n_vec++; if (d1_data_in_ready !== 1'b1 || d1_weight_ready !== 1'b1) begin n_err++; $display("FAIL d1_ready k %0d: got %b%b want 11", k, d1_data_in_ready, d1_weight_ready); end
            if (k > 0) begin
                n_vec++; if (d1_data_out_valid !== 1'b1 || d1_data_out !== DOUT1'(prev)) begin n_err++; $display("FAIL d1_stream k %0d: got %b/%h want 1/%h", k, d1_data_out_valid, d1_data_out, DOUT1'(prev)); end
            end
            prev = (k < 4) ? 70 : beat_value(d1_data_in, d1_weight);
            @(posedge clk); #1;
        end
        d1_data_in_valid = 1'b0; d1_weight_valid = 1'b0;
        #1;
        n_vec++; if (d1_data_out_valid !== 1'b1 || d1_data_out !== DOUT1'(prev)) begin n_err++; $display("FAIL d1_last: got %b/%h want 1/%h", d1_data_out_valid, d1_data_out, DOUT1'(prev)); end
        @(posedge clk); #1;
        n_vec++; if (d1_data_out_valid !== 1'b0) begin n_err++; $display("FAIL d1_drain: got %b want 0", d1_data_out_valid); end
        $display("test_depth_one last result=%0d", prev);
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0; weight = '0;
        data_in_valid = 1'b0; weight_valid = 1'b0; data_out_ready = 1'b1;
        d1_data_in = '0; d1_weight = '0;
        d1_data_in_valid = 1'b0; d1_weight_valid = 1'b0; d1_data_out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_ones();
        test_signed();
        test_random_join();
        test_backpressure();
        test_reset_mid_group();
        test_depth_one();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
